// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types and width helpers for the comparator sweep checker.
//   state_t  - sweep controller states
//   triple_t - comparator result triple, ordered {gt, eq, lt}
//   cnt_width(w) - width of the error counter for a w-bit comparator
//   HOLD_W   - width of the per-vector hold counter (SETTLE is 0..15)
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } triple_t;

  localparam int HOLD_W = 4;

  // 4^w vectors can all fail, which needs 2*w+1 bits.
  function automatic int cnt_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/cmp_golden.sv
// cmp_golden: combinational reference comparator.
// Ports:
//   a, b - WIDTH-bit unsigned operands
//   res  - {gt, eq, lt}, exactly one bit set
module cmp_golden
  import cmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output triple_t          res
);

  always_comb begin
    res.gt = (a > b);
    res.eq = (a == b);
    res.lt = (a < b);
  end

endmodule

// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker: exhaustively sweeps all (A,B) operand pairs into an
// external comparator, holds each pair for SETTLE+1 cycles, samples the
// comparator triple on the last hold edge and counts mismatches against
// cmp_golden.
// Ports:
//   clk, rst              - clock, async active-high reset
//   start                 - one-cycle sweep request (ignored while busy)
//   a_out, b_out          - operands driven to the comparator
//   gt_in, eq_in, lt_in   - comparator results
//   busy, done, pass      - sweep status; pass valid while done=1
//   err_count             - number of mismatching vectors
//   first_err_a/b, first_err_valid - operands of the first mismatch
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_HOLD   | driving a vector, counting hold cycles, sampling
// ST_FINISH | sweep complete, results frozen until next start
module cmp_sweep_checker
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             gt_in,
  input  logic             eq_in,
  input  logic             lt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_valid
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0]  OP_MAX   = '1;
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(SETTLE);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [WIDTH-1:0]    fa_q, fa_d, fb_q, fb_d;
  logic                fv_q, fv_d;
  logic                pass_q, pass_d;

  triple_t expected;
  triple_t sampled;
  logic    mismatch;

  cmp_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (a_q),
    .b   (b_q),
    .res (expected)
  );

  assign sampled  = {gt_in, eq_in, lt_in};
  // Any differing bit is a single error, so non-one-hot triples fail too.
  assign mismatch = (sampled != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fv_d    = fv_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d = ST_HOLD;
          a_d     = '0;
          b_d     = '0;
          hold_d  = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_HOLD: begin
        if (hold_q == HOLD_END) begin
          if (mismatch) begin
            err_d = err_q + CNT_W'(1);
            if (!fv_q) begin
              fa_d = a_q;
              fb_d = b_q;
              fv_d = 1'b1;
            end
          end
          hold_d = '0;
          if ((a_q == OP_MAX) && (b_q == OP_MAX)) begin
            // Operands stay on the last vector; pass includes this sample.
            state_d = ST_FINISH;
            pass_d  = (err_d == '0);
          end else if (b_q == OP_MAX) begin
            a_d = a_q + WIDTH'(1);
            b_d = '0;
          end else begin
            b_d = b_q + WIDTH'(1);
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign busy            = (state_q == ST_HOLD);
  assign done            = (state_q == ST_FINISH);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_a     = fa_q;
  assign first_err_b     = fb_q;
  assign first_err_valid = fv_q;

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// tb_cmp_sweep_checker: directed bench for cmp_sweep_checker. dut1 runs
// SETTLE=0 against a bench comparator with selectable faults; dut2 runs
// SETTLE=2 against a comparator delayed by two registers.
module tb_cmp_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut1 signals
  logic       rst1, start1;
  logic [1:0] a1, b1, fa1, fb1;
  logic       gt1, eq1, lt1, busy1, done1, pass1, fv1;
  logic [4:0] err1;
  int         mode;  // 0 ok, 1 eq stuck 0, 2 gt/lt swapped, 3 delayed 2

  // dut2 signals
  logic       rst2, start2;
  logic [1:0] a2, b2, fa2, fb2;
  logic       gt2, eq2, lt2, busy2, done2, pass2, fv2;
  logic [4:0] err2;

  logic [2:0] ideal1, dly1a, dly1b, ideal2, dly2a, dly2b;

  assign ideal1 = {a1 > b1, a1 == b1, a1 < b1};
  assign ideal2 = {a2 > b2, a2 == b2, a2 < b2};

  always @(posedge clk) begin
    dly1a <= ideal1;
    dly1b <= dly1a;
    dly2a <= ideal2;
    dly2b <= dly2a;
  end

  always_comb begin
    {gt1, eq1, lt1} = ideal1;
    case (mode)
      1: {gt1, eq1, lt1} = {ideal1[2], 1'b0, ideal1[0]};
      2: {gt1, eq1, lt1} = {ideal1[0], ideal1[1], ideal1[2]};
      3: {gt1, eq1, lt1} = dly1b;
      default: {gt1, eq1, lt1} = ideal1;
    endcase
  end

  assign {gt2, eq2, lt2} = dly2b;

  cmp_sweep_checker #(.WIDTH(2), .SETTLE(0)) dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .a_out(a1), .b_out(b1),
    .gt_in(gt1), .eq_in(eq1), .lt_in(lt1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_valid(fv1)
  );

  cmp_sweep_checker #(.WIDTH(2), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2),
    .a_out(a2), .b_out(b2),
    .gt_in(gt2), .eq_in(eq2), .lt_in(lt2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_a(fa2), .first_err_b(fb2), .first_err_valid(fv2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic pulse_start2();
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
  endtask

  // Cycles counted from the start edge; cyc carries any already elapsed.
  task automatic wait_done1(inout int cyc);
    while (!done1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done1) chk("dut1_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int cyc;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0; mode = 0;
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    chk("rst_a", a1, 0);
    idle(3);
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;

    // Correct comparator: vector order, 16-cycle sweep, pass.
    pulse_start1();
    cyc = 0;
    while (!done1 && cyc < 200) begin
      if (cyc < 16) begin
        chk("order_a", a1, cyc / 4);
        chk("order_b", b1, cyc % 4);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("ok_cycles", cyc, 16);
    chk("ok_pass", pass1, 1);
    chk("ok_err", err1, 0);
    chk("ok_fv", fv1, 0);
    chk("ok_busy", busy1, 0);
    chk("ok_last_ab", {a1, b1}, 4'hF);
    idle(3);
    chk("finish_hold_done", done1, 1);
    chk("finish_hold_pass", pass1, 1);

    // eq stuck at 0: the four diagonal vectors fail.
    mode = 1;
    pulse_start1();
    chk("restart_done", done1, 0);
    chk("restart_busy", busy1, 1);
    chk("restart_pass", pass1, 0);
    cyc = 0;
    wait_done1(cyc);
    chk("eq0_err", err1, 4);
    chk("eq0_pass", pass1, 0);
    chk("eq0_fa", fa1, 0);
    chk("eq0_fb", fb1, 0);
    chk("eq0_fv", fv1, 1);

    // gt/lt swapped: every off-diagonal vector fails.
    mode = 2;
    pulse_start1();
    cyc = 0;
    wait_done1(cyc);
    chk("swap_err", err1, 12);
    chk("swap_fa", fa1, 0);
    chk("swap_fb", fb1, 1);
    chk("swap_pass", pass1, 0);

    // start during a sweep is ignored.
    mode = 0;
    pulse_start1();
    idle(2);
    pulse_start1();
    cyc = 3;
    chk("ign_busy", busy1, 1);
    chk("ign_ab", {a1, b1}, 4'd3);
    wait_done1(cyc);
    chk("ign_cycles", cyc, 16);
    chk("ign_pass", pass1, 1);

    // Reset mid-sweep at vector (1,1) after partial errors.
    mode = 2;
    pulse_start1();
    cyc = 0;
    while (!(a1 == 2'd1 && b1 == 2'd1) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rst_mid_reach", cyc, 5);
    chk("rst_mid_pre_err", err1, 4);
    rst1 = 1'b1;
    #1;
    chk("rst_mid_a", a1, 0);
    chk("rst_mid_b", b1, 0);
    chk("rst_mid_busy", busy1, 0);
    chk("rst_mid_done", done1, 0);
    chk("rst_mid_pass", pass1, 0);
    chk("rst_mid_err", err1, 0);
    chk("rst_mid_fa", fa1, 0);
    chk("rst_mid_fb", fb1, 0);
    chk("rst_mid_fv", fv1, 0);
    idle(2);
    @(negedge clk);
    rst1 = 1'b0;
    mode = 0;
    idle(3);
    chk("post_rst_idle", busy1, 0);
    chk("post_rst_done", done1, 0);
    pulse_start1();
    cyc = 0;
    wait_done1(cyc);
    chk("post_rst_cycles", cyc, 16);
    chk("post_rst_pass", pass1, 1);
    chk("post_rst_err", err1, 0);

    // Two-register-delayed comparator without settle time fails.
    mode = 3;
    pulse_start1();
    cyc = 0;
    wait_done1(cyc);
    chk("dly_s0_pass", pass1, 0);

    // Same comparator with SETTLE=2 passes in 48 cycles.
    pulse_start2();
    cyc = 0;
    while (!done2 && cyc < 200) begin
      if (cyc == 3) chk("s2_third_ab", {a2, b2}, 4'd1);
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("s2_cycles", cyc, 48);
    chk("s2_pass", pass2, 1);
    chk("s2_err", err2, 0);
    chk("s2_fv", fv2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
